// File: rtl/jtag_tap_controller.sv
// ---------------------------------------------------------------------------
// jtag_tap_controller
//   IEEE 1149.1 16-state TAP controller. Decodes TMS on rising tck and
//   produces the DR/IR capture/shift/update strobes, gated DR/IR clocks,
//   the tdo output enable and the IR/DR select for the tdo mux.
//
// Ports:
//   tck        in   JTAG test clock (both edges used)
//   reset      in   synchronous active-high reset, sampled on tck edges
//   tms        in   test mode select, sampled on rising tck
//   state      out  current TAP state (1149.1 encoding)
//   tapReset   out  high while in Test-Logic-Reset (falling-edge register)
//   captureDR  out  current state is Capture-DR
//   shiftDR    out  current state is Shift-DR
//   clockDR    out  gated tck for data registers, rests high
//   updateDR   out  DR update strobe, rises on falling tck in Update-DR
//   captureIR  out  current state is Capture-IR
//   shiftIR    out  current state is Shift-IR
//   clockIR    out  gated tck for the instruction register, rests high
//   updateIR   out  IR update strobe, rises on falling tck in Update-IR
//   select     out  1 = IR path drives tdo, 0 = DR path
//   tdoEn      out  tdo output enable
// ---------------------------------------------------------------------------
module jtag_tap_controller #(
    parameter logic [3:0] RESET_STATE = 4'hF
) (
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] state,
    output logic       tapReset,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       clockDR,
    output logic       updateDR,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       clockIR,
    output logic       updateIR,
    output logic       select,
    output logic       tdoEn
);

    localparam logic [3:0] TLR     = 4'hF;
    localparam logic [3:0] RTI     = 4'hC;
    localparam logic [3:0] SEL_DR  = 4'h7;
    localparam logic [3:0] CAP_DR  = 4'h6;
    localparam logic [3:0] SH_DR   = 4'h2;
    localparam logic [3:0] EX1_DR  = 4'h1;
    localparam logic [3:0] PAU_DR  = 4'h3;
    localparam logic [3:0] EX2_DR  = 4'h0;
    localparam logic [3:0] UPD_DR  = 4'h5;
    localparam logic [3:0] SEL_IR  = 4'h4;
    localparam logic [3:0] CAP_IR  = 4'hE;
    localparam logic [3:0] SH_IR   = 4'hA;
    localparam logic [3:0] EX1_IR  = 4'h9;
    localparam logic [3:0] PAU_IR  = 4'hB;
    localparam logic [3:0] EX2_IR  = 4'h8;
    localparam logic [3:0] UPD_IR  = 4'hD;

    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic       drClkEn;
    logic       irClkEn;

    // State register
    always_ff @(posedge tck) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // Output decode of the current state
    always_comb begin
        captureDR = 1'b0;
        shiftDR   = 1'b0;
        captureIR = 1'b0;
        shiftIR   = 1'b0;
        select    = 1'b0;
        case (state_q)
            CAP_DR: captureDR = 1'b1;
            SH_DR:  shiftDR   = 1'b1;
            CAP_IR: begin captureIR = 1'b1; select = 1'b1; end
            SH_IR:  begin shiftIR   = 1'b1; select = 1'b1; end
            SEL_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR: select = 1'b1;
            default: ;
        endcase
    end

    // Falling-edge registers: they change only while tck is low, so the
    // gated clocks below cannot glitch and the update strobes rise
    // mid-cycle after shift data has settled.
    always_ff @(negedge tck) begin
        if (reset) begin
            drClkEn  <= 1'b0;
            irClkEn  <= 1'b0;
            updateDR <= 1'b0;
            updateIR <= 1'b0;
            tdoEn    <= 1'b0;
            tapReset <= 1'b1;   // reset drives the FSM into Test-Logic-Reset
        end else begin
            drClkEn  <= (state_q == CAP_DR) || (state_q == SH_DR);
            irClkEn  <= (state_q == CAP_IR) || (state_q == SH_IR);
            updateDR <= (state_q == UPD_DR);
            updateIR <= (state_q == UPD_IR);
            tdoEn    <= (state_q == SH_DR) || (state_q == SH_IR);
            tapReset <= (state_q == TLR);
        end
    end

    // Gated clocks rest high; a rising edge appears only on the rising tck
    // that leaves Capture-X or Shift-X.
    assign clockDR = tck | ~drClkEn;
    assign clockIR = tck | ~irClkEn;
    assign state   = state_q;

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 16-state TAP controller.
- Sits directly upstream of the data registers, including the device identification register. It decodes TMS on tck and produces the DR/IR control strobes: captureDR, shiftDR, updateDR and the gated clockDR, plus the IR equivalents.
- Also produces the tdo output enable and the IR/DR select for the tdo mux.

Parameters:
- RESET_STATE, 4'hF, encoding loaded on reset. Test-Logic-Reset; must not be overridden in product builds.

Ports:
- tck  input  1  JTAG test clock; the only clock. Both edges are used.
- reset  input  1  synchronous, active-high reset, sampled on tck edges.
- tms  input  1  test mode select, sampled on rising tck.
- state  output  4  current TAP state (1149.1 encoding), for debug.
- tapReset  output  1  high while in Test-Logic-Reset; clears the instruction register downstream.
- captureDR  output  1  current state is Capture-DR.
- shiftDR  output  1  current state is Shift-DR.
- clockDR  output  1  gated tck for data registers.
- updateDR  output  1  update strobe for data registers.
- captureIR  output  1  current state is Capture-IR.
- shiftIR  output  1  current state is Shift-IR.
- clockIR  output  1  gated tck for the instruction register.
- updateIR  output  1  update strobe for the instruction register.
- select  output  1  1 = IR path drives tdo, 0 = DR path.
- tdoEn  output  1  tdo output enable.

Behaviour:
- One clock (tck), reset synchronous active-high. The port names tck and reset are fixed.
- State encoding (1149.1):
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- State register updates on rising tck. Next state when tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapX: ShX / Ex1X
  - ShX: ShX / Ex1X
  - Ex1X: PauseX / UpdX
  - PauseX: PauseX / Ex2X
  - Ex2X: ShX / UpdX
  - UpdX: RTI / SelDR
- reset high at a rising tck forces state=TLR, overriding tms. Reset mid-shift aborts the shift; no update strobe is issued.
- Five consecutive rising tck with tms=1 reach TLR from any state.
- captureDR, shiftDR, captureIR, shiftIR and select are combinational decodes of the current state. They are therefore valid for the whole cycle before the rising tck that performs the capture/shift.
- select = 1 in SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR; 0 otherwise.
- Falling-tck registers (also cleared synchronously by reset on the falling edge):
  - drClkEn = state in {CapDR, ShDR}
  - irClkEn = state in {CapIR, ShIR}
  - updateDR = (state==UpdDR)
  - updateIR = (state==UpdIR)
  - tdoEn = state in {ShDR, ShIR}
  - tapReset = (state==TLR)
- Gated clocks:
  - clockDR = tck OR NOT drClkEn; clockIR = tck OR NOT irClkEn.
  - The rest level is high. A rising clockDR edge coincides with each rising tck leaving CapDR or ShDR. No glitches, because the enable changes only while tck is low.
- updateDR/updateIR go high at the falling tck inside UpdX and drop at the next falling tck. The strobe rises mid-cycle, so downstream latches sample stable shift data.
- Outputs after reset (once both edges have occurred):
  - state=F, tapReset=1, select=0
  - capture/shift/update strobes=0, tdoEn=0
  - clockDR=clockIR=1 (held high)

Test Plan:
- Reset: assert reset for 2 tck with tms=0 → state=F, tapReset=1, clockDR=1, tdoEn=0. Release reset, tms=0 for 1 tck → state=C, tapReset=0 after the next falling edge.
- DR scan, ID read:
  - From RTI, tms=1,0,0 → state=6 (captureDR=1), then 2.
  - Hold tms=0 for 31 tck, then tms=1 → exactly 32 rising clockDR edges after capture plus 1 capture edge (33 total); tdoEn=1 during Shift-DR.
  - A downstream ID register returns the programmed 32-bit ID LSB-first.
- Update timing: tms=1,1 from ShDR → Ex1DR, then UpdDR. updateDR=1 for exactly one tck period, rising on falling tck; clockDR stays high throughout.
- IR scan: from RTI, tms=1,1,0,0 → CapIR(E), ShIR(A); select=1, clockIR pulses, clockDR silent. Exit via tms=1,1 → updateIR pulse, then state=C with tms=0.
- Pause/Ex2 loop: ShDR, tms=1,0,0,1,0 → Ex1DR, PauseDR, PauseDR, Ex2DR, ShDR. No clockDR edges and no updateDR while paused; shifting resumes.
- Recovery: from ShDR, tms=1 for 5 tck → state=F, tapReset=1. Separately, assert reset mid-ShIR → state=F next rising tck and no updateIR pulse.
